// File: rtl/i2c_slave_regs_if.sv
// ============================================================================
// i2c_slave_regs_if : bus pins and register-bank status of the I2C target
// Revision 1.0
// ============================================================================
`default_nettype none

interface i2c_slave_regs_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_out;
    logic        sda_select;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic [31:0] bank_flat;
    logic        busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_out,
        output sda_select,
        output wr_strobe,
        output wr_index,
        output bank_flat,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        input  sda_out,
        input  sda_select,
        input  wr_strobe,
        input  wr_index,
        input  bank_flat,
        input  busy
    );
endinterface

`default_nettype wire

// File: rtl/i2c_slave_regs.sv
// ============================================================================
// i2c_slave_regs : I2C target with a 4-byte register bank (pointer + data)
// Optional macro GENERAL_CALL_EN enables general-call reset (byte 0x06).
// Revision 1.0
// ============================================================================
`default_nettype none

module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDRESS = 7'b1011010,
    parameter logic [7:0] REG_RESET     = 8'b11001100
) (
    input  wire logic         clk,
    input  wire logic         rst_,
    i2c_slave_regs_if.slave   bus
);

`ifdef GENERAL_CALL_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_PTR, S_RX_DATA, S_TX_BYTE, S_TX_ACK, S_WAIT
    } state_t;

    state_t      state_q;
    logic        scl_s1_q, scl_s2_q, scl_prev_q;
    logic        sda_s1_q, sda_s2_q, sda_prev_q;
    logic [3:0]  bitcnt_q;
    logic [7:0]  shift_q;
    logic [1:0]  ptr_q;
    logic        rw_q, ack_q, rx_ack_q, gc_q, gc_reset_q;
    logic        sda_out_q, sda_select_q, wr_strobe_q, busy_q;
    logic [1:0]  wr_index_q;
    logic [7:0]  bank_q [4];

    logic scl_rise, scl_fall, start_det, stop_det, addr_match, gc_match;

    assign scl_rise   = scl_s2_q & ~scl_prev_q;
    assign scl_fall   = ~scl_s2_q & scl_prev_q;
    assign start_det  = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_det   = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign gc_match   = GC_EN && (shift_q == 8'h00);
    assign addr_match = (shift_q[7:1] == SLAVE_ADDRESS) || gc_match;

    assign bus.sda_out    = sda_out_q;
    assign bus.sda_select = sda_select_q;
    assign bus.wr_strobe  = wr_strobe_q;
    assign bus.wr_index   = wr_index_q;
    assign bus.busy       = busy_q;
    assign bus.bank_flat  = {bank_q[3], bank_q[2], bank_q[1], bank_q[0]};

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q      <= S_IDLE;
            scl_s1_q     <= 1'b1;
            scl_s2_q     <= 1'b1;
            scl_prev_q   <= 1'b1;
            sda_s1_q     <= 1'b1;
            sda_s2_q     <= 1'b1;
            sda_prev_q   <= 1'b1;
            bitcnt_q     <= 4'd0;
            shift_q      <= 8'h00;
            ptr_q        <= 2'd0;
            rw_q         <= 1'b0;
            ack_q        <= 1'b0;
            rx_ack_q     <= 1'b0;
            gc_q         <= 1'b0;
            gc_reset_q   <= 1'b0;
            sda_out_q    <= 1'b1;
            sda_select_q <= 1'b0;
            wr_strobe_q  <= 1'b0;
            wr_index_q   <= 2'd0;
            busy_q       <= 1'b0;
            for (int i = 0; i < 4; i++) bank_q[i] <= REG_RESET;
        end else begin
            scl_s1_q   <= bus.scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= bus.sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
            wr_strobe_q <= 1'b0;

            // General-call reset lands one clk after its ACK was driven
            if (gc_reset_q) begin
                gc_reset_q  <= 1'b0;
                for (int i = 0; i < 4; i++) bank_q[i] <= REG_RESET;
                ptr_q       <= 2'd0;
                wr_strobe_q <= 1'b1;
                wr_index_q  <= 2'd0;
            end

            if (start_det) begin
                state_q      <= S_ADDR;
                bitcnt_q     <= 4'd0;
                sda_select_q <= 1'b0;
                busy_q       <= 1'b0;
                ack_q        <= 1'b0;
                gc_q         <= 1'b0;
            end else if (stop_det) begin
                state_q      <= S_IDLE;
                sda_select_q <= 1'b0;
                busy_q       <= 1'b0;
                ack_q        <= 1'b0;
                gc_q         <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: begin
                        if (scl_rise && bitcnt_q < 4'd8) begin
                            shift_q  <= {shift_q[6:0], sda_s2_q};
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            if (addr_match && !(gc_match && shift_q[0])) begin
                                sda_select_q <= 1'b1;
                                sda_out_q    <= 1'b0;
                                busy_q       <= 1'b1;
                                rw_q         <= shift_q[0];
                                gc_q         <= gc_match;
                                state_q      <= S_ADDR_ACK;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bitcnt_q <= 4'd0;
                            if (rw_q) begin
                                shift_q      <= bank_q[ptr_q];
                                sda_select_q <= ~bank_q[ptr_q][7];
                                sda_out_q    <= 1'b0;
                                state_q      <= S_TX_BYTE;
                            end else begin
                                sda_select_q <= 1'b0;
                                state_q      <= S_RX_PTR;
                            end
                        end
                    end
                    S_RX_PTR, S_RX_DATA: begin
                        if (scl_fall && ack_q) begin
                            sda_select_q <= 1'b0;
                            ack_q        <= 1'b0;
                            bitcnt_q     <= 4'd0;
                            if (gc_q) state_q <= S_WAIT;
                        end else if (scl_rise && !ack_q && bitcnt_q < 4'd8) begin
                            shift_q  <= {shift_q[6:0], sda_s2_q};
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && !ack_q && bitcnt_q == 4'd8) begin
                            sda_select_q <= 1'b1;
                            sda_out_q    <= 1'b0;
                            ack_q        <= 1'b1;
                            if (state_q == S_RX_PTR) begin
                                if (gc_q) begin
                                    gc_reset_q <= (shift_q == 8'h06);
                                end else begin
                                    ptr_q   <= shift_q[1:0];
                                    state_q <= S_RX_DATA;
                                end
                            end else begin
                                bank_q[ptr_q] <= shift_q;
                                wr_strobe_q   <= 1'b1;
                                wr_index_q    <= ptr_q;
                                ptr_q         <= ptr_q + 2'd1;
                            end
                        end
                    end
                    S_TX_BYTE: begin
                        if (scl_rise && bitcnt_q < 4'd8) begin
                            bitcnt_q <= bitcnt_q + 4'd1;
                        end else if (scl_fall && bitcnt_q == 4'd8) begin
                            sda_select_q <= 1'b0;
                            bitcnt_q     <= 4'd0;
                            rx_ack_q     <= 1'b0;
                            state_q      <= S_TX_ACK;
                        end else if (scl_fall && bitcnt_q != 4'd0) begin
                            sda_select_q <= ~shift_q[6];
                            shift_q      <= {shift_q[6:0], 1'b0};
                        end
                    end
                    S_TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2_q) begin
                                ptr_q    <= ptr_q + 2'd1;
                                rx_ack_q <= 1'b1;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end else if (scl_fall && rx_ack_q) begin
                            shift_q      <= bank_q[ptr_q];
                            sda_select_q <= ~bank_q[ptr_q][7];
                            sda_out_q    <= 1'b0;
                            bitcnt_q     <= 4'd0;
                            state_q      <= S_TX_BYTE;
                        end
                    end
                    S_IDLE, S_WAIT: begin
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
